mem_stage: RTL and testbench

//  Memory-access pipeline stage sitting directly upstream of the write stage.

---
 rtl/mem_stage.sv | 211 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store over a req/ack port,
// formats load data and strobes the result toward the write stage.
module mem_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] reg_data,
  output logic        completed,
  output logic        fault,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [15:0] LAST = 16'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        load_q, load_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rd_q, rd_d;
  logic        fault_q, fault_d;
  logic        tmo_q, tmo_d;

  logic        is_mem;
  logic        f3_ok;
  logic        misal;
  logic        bad;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [31:0] ld_sh;
  logic [31:0] ld_val;

  // Decode legality, store lanes and load formatting
  always_comb begin
    is_mem  = is_load | is_store;
    f3_ok   = 1'b0;
    misal   = 1'b0;
    st_data = store_data;
    st_strb = 4'b1111;
    unique case (1'b1)
      funct3 == 3'b000: begin
        f3_ok   = 1'b1;
        st_data = {4{store_data[7:0]}};
        st_strb = 4'b0001 << addr[1:0];
      end
      funct3 == 3'b001: begin
        f3_ok   = 1'b1;
        misal   = addr[0];
        st_data = {2{store_data[15:0]}};
        st_strb = addr[1] ? 4'b1100 : 4'b0011;
      end
      funct3 == 3'b010: begin
        f3_ok = 1'b1;
        misal = addr[1:0] != 2'b00;
      end
      funct3 == 3'b100: f3_ok = is_load;
      funct3 == 3'b101: begin
        f3_ok = is_load;
        misal = addr[0];
      end
      default: f3_ok = 1'b0;
    endcase
    bad = is_mem & (~f3_ok | misal);

    ld_sh  = mem_rdata >> {lane_q, 3'b000};
    ld_val = mem_rdata;
    unique case (1'b1)
      f3_q[1:0] == 2'b00:
        ld_val = {{24{~f3_q[2] & ld_sh[7]}}, ld_sh[7:0]};
      f3_q[1:0] == 2'b01:
        ld_val = {{16{~f3_q[2] & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enabled) state_d = (is_mem && !bad) ? BUSY : DONE;
      BUSY: if (mem_ack || cnt_q == LAST) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture on start, resolve in BUSY
  always_comb begin
    cnt_d   = cnt_q;
    load_d  = load_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rd_d    = rd_q;
    fault_d = fault_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: if (enabled) begin
        load_d  = is_load;
        f3_d    = funct3;
        lane_d  = addr[1:0];
        cnt_d   = '0;
        fault_d = 1'b0;
        tmo_d   = 1'b0;
        if (!is_mem) begin
          rd_d = alu_result;
        end else if (bad) begin
          rd_d    = '0;
          fault_d = 1'b1;
        end else begin
          we_d    = is_store;
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = st_data;
          wstrb_d = is_store ? st_strb : 4'b0000;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          rd_d = load_q ? ld_val : 32'h0;
        end else if (cnt_q == LAST) begin
          rd_d  = '0;
          tmo_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        fault_d = 1'b0;
        tmo_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      load_q  <= 1'b0;
      f3_q    <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs: request in BUSY, strobes only in DONE
  always_comb begin
    mem_req   = state_q == BUSY;
    completed = state_q == DONE;
    fault     = completed & fault_q;
    timeout   = completed & tmo_q;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wstrb = wstrb_q;
    reg_data  = rd_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with MAX_WAIT=4: loads, stores,
// faults, non-mem pass-through, timeout and mid-access reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enabled;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] reg_data;
  logic        completed;
  logic        fault;
  logic        timeout;

  int vecs = 0;
  int errs = 0;

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled),
    .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr),
    .alu_result(alu_result), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .reg_data(reg_data),
    .completed(completed), .fault(fault),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic ld, input logic st,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] alu,
                       input logic [31:0] sd);
    @(negedge clk);
    enabled    = 1'b1;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    alu_result = alu;
    store_data = sd;
  endtask

  task automatic quiet();
    @(negedge clk);
    enabled    = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b111;
    addr       = 32'hFFFF_FFFF;
    alu_result = 32'h0;
    store_data = 32'h0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enabled = 1'b0; is_load = 1'b0;
    is_store = 1'b0; funct3 = 3'b0; addr = 32'h0;
    alu_result = 32'h0; store_data = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #23;
    vecs++;
    if ({mem_req, mem_we, completed, fault, timeout} !== 5'b0) begin
      errs++;
      $display("FAIL reset_flags got %b want 00000",
               {mem_req, mem_we, completed, fault, timeout});
    end
    vecs++;
    if ({mem_addr, mem_wdata, reg_data, mem_wstrb} !== 100'h0) begin
      errs++;
      $display("FAIL reset_data got %h %h %h %h want zeros",
               mem_addr, mem_wdata, reg_data, mem_wstrb);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_lb();
    start(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h0);
    tick();
    vecs++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr} !== {2'b10, 4'b0, 32'h100}) begin
      errs++;
      $display("FAIL lb_req got req=%b we=%b strb=%b addr=%h want 1 0 0000 100",
               mem_req, mem_we, mem_wstrb, mem_addr);
    end
    quiet();
    tick();
    vecs++;
    if (mem_req !== 1'b1 || completed !== 1'b0 || mem_addr !== 32'h100) begin
      errs++;
      $display("FAIL lb_wait got req=%b cmp=%b addr=%h want 1 0 100",
               mem_req, completed, mem_addr);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
    tick();
    vecs++;
    if (completed !== 1'b1 || mem_req !== 1'b0 || reg_data !== 32'hFFFF_FF80
        || fault !== 1'b0 || timeout !== 1'b0) begin
      errs++;
      $display("FAIL lb_done got cmp=%b req=%b data=%h f=%b t=%b want 1 0 ffffff80 0 0",
               completed, mem_req, reg_data, fault, timeout);
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick();
    vecs++;
    if (completed !== 1'b0 || reg_data !== 32'hFFFF_FF80) begin
      errs++;
      $display("FAIL lb_hold got cmp=%b data=%h want 0 ffffff80",
               completed, reg_data);
    end
  endtask

  task automatic test_sh();
    start(0, 1, 3'b001, 32'h0000_0202, 32'h0, 32'h1234_ABCD);
    tick();
    vecs++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200
        || mem_wstrb !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD) begin
      errs++;
      $display("FAIL sh_req got req=%b we=%b addr=%h strb=%b wd=%h want 1 1 200 1100 abcdabcd",
               mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
    end
    @(negedge clk);
    enabled = 1'b0; mem_ack = 1'b1;
    tick();
    vecs++;
    if (completed !== 1'b1 || reg_data !== 32'h0 || fault !== 1'b0) begin
      errs++;
      $display("FAIL sh_done got cmp=%b data=%h f=%b want 1 0 0",
               completed, reg_data, fault);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_sb_ignore();
    start(0, 1, 3'b000, 32'h0000_0301, 32'h0, 32'h0000_775A);
    tick();
    vecs++;
    if (mem_wstrb !== 4'b0010 || mem_wdata !== 32'h5A5A_5A5A
        || mem_addr !== 32'h300) begin
      errs++;
      $display("FAIL sb_req got strb=%b wd=%h addr=%h want 0010 5a5a5a5a 300",
               mem_wstrb, mem_wdata, mem_addr);
    end
    start(0, 1, 3'b010, 32'h0000_0500, 32'h0, 32'h1111_2222);
    tick();
    vecs++;
    if (mem_req !== 1'b1 || mem_wstrb !== 4'b0010 || mem_addr !== 32'h300
        || mem_wdata !== 32'h5A5A_5A5A) begin
      errs++;
      $display("FAIL sb_ignore got req=%b strb=%b addr=%h wd=%h want 1 0010 300 5a5a5a5a",
               mem_req, mem_wstrb, mem_addr, mem_wdata);
    end
    @(negedge clk);
    enabled = 1'b0; mem_ack = 1'b1;
    tick();
    @(negedge clk);
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_fault();
    logic [2:0]  f3s [3] = '{3'b010, 3'b011, 3'b101};
    logic        sts [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] as  [3] = '{32'h101, 32'h100, 32'h103};
    for (int i = 0; i < 3; i++) begin
      start(!sts[i], sts[i], f3s[i], as[i], 32'h5555_5555, 32'hFFFF_FFFF);
      tick();
      vecs++;
      if (completed !== 1'b1 || fault !== 1'b1 || mem_req !== 1'b0
          || reg_data !== 32'h0 || timeout !== 1'b0) begin
        errs++;
        $display("FAIL fault_%0d got cmp=%b f=%b req=%b data=%h t=%b want 1 1 0 0 0",
                 i, completed, fault, mem_req, reg_data, timeout);
      end
      quiet();
      tick();
      vecs++;
      if (completed !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0) begin
        errs++;
        $display("FAIL fault_clr_%0d got cmp=%b f=%b req=%b want 0 0 0",
                 i, completed, fault, mem_req);
      end
    end
  endtask

  task automatic test_nonmem();
    start(0, 0, 3'b000, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0);
    tick();
    vecs++;
    if (completed !== 1'b1 || reg_data !== 32'hDEAD_BEEF || mem_req !== 1'b0
        || fault !== 1'b0) begin
      errs++;
      $display("FAIL nonmem got cmp=%b data=%h req=%b f=%b want 1 deadbeef 0 0",
               completed, reg_data, mem_req, fault);
    end
    quiet();
    tick();
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b000};
    logic [31:0] as  [6] = '{32'h10, 32'h12, 32'h11, 32'h10, 32'h14, 32'h12};
    logic [31:0] rds [6] = '{32'h1234_567F, 32'h8001_0000, 32'h0000_F000,
                             32'h1234_8765, 32'hCAFE_BABE, 32'h0080_0000};
    logic [31:0] exp [6] = '{32'h0000_007F, 32'hFFFF_8001, 32'h0000_00F0,
                             32'h0000_8765, 32'hCAFE_BABE, 32'hFFFF_FF80};
    for (int i = 0; i < 6; i++) begin
      start(1, 0, f3s[i], as[i], 32'h0, 32'h0);
      tick();
      @(negedge clk);
      enabled = 1'b0; mem_ack = 1'b1; mem_rdata = rds[i];
      tick();
      vecs++;
      if (completed !== 1'b1 || reg_data !== exp[i]) begin
        errs++;
        $display("FAIL load_%0d got cmp=%b data=%h want 1 %h",
                 i, completed, reg_data, exp[i]);
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      tick();
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int guard = 0;
    start(1, 0, 3'b010, 32'h0000_0400, 32'h0, 32'h0);
    tick();
    quiet();
    while (mem_req === 1'b1 && guard < 10) begin
      n++;
      guard++;
      tick();
    end
    vecs++;
    if (n !== 4) begin
      errs++;
      $display("FAIL tmo_len got %0d req cycles want 4", n);
    end
    vecs++;
    if (completed !== 1'b1 || timeout !== 1'b1 || reg_data !== 32'h0
        || fault !== 1'b0) begin
      errs++;
      $display("FAIL tmo_done got cmp=%b t=%b data=%h f=%b want 1 1 0 0",
               completed, timeout, reg_data, fault);
    end
    tick();
    vecs++;
    if (completed !== 1'b0 || timeout !== 1'b0) begin
      errs++;
      $display("FAIL tmo_clr got cmp=%b t=%b want 0 0", completed, timeout);
    end
  endtask

  task automatic test_ack_last();
    start(1, 0, 3'b101, 32'h0000_0102, 32'h0, 32'h0);
    tick();
    quiet();
    tick();
    tick();
    tick();
    vecs++;
    if (mem_req !== 1'b1) begin
      errs++;
      $display("FAIL last_wait got req=%b want 1", mem_req);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF_1234;
    tick();
    vecs++;
    if (completed !== 1'b1 || timeout !== 1'b0 || reg_data !== 32'h0000_BEEF) begin
      errs++;
      $display("FAIL last_ack got cmp=%b t=%b data=%h want 1 0 0000beef",
               completed, timeout, reg_data);
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick();
  endtask

  task automatic test_reset_busy();
    start(1, 0, 3'b000, 32'h0000_0700, 32'h0, 32'h0);
    tick();
    quiet();
    #2;
    rstn = 1'b0;
    #1;
    vecs++;
    if (mem_req !== 1'b0 || completed !== 1'b0 || mem_addr !== 32'h0) begin
      errs++;
      $display("FAIL rst_busy got req=%b cmp=%b addr=%h want 0 0 0",
               mem_req, completed, mem_addr);
    end
    @(negedge clk);
    rstn = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0000_0011;
    tick();
    @(negedge clk);
    mem_ack = 1'b0;
    tick();
    vecs++;
    if (mem_req !== 1'b0 || completed !== 1'b0 || reg_data !== 32'h0) begin
      errs++;
      $display("FAIL stray_ack got req=%b cmp=%b data=%h want 0 0 0",
               mem_req, completed, reg_data);
    end
    test_nonmem();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_sb_ignore();
    test_fault();
    test_nonmem();
    test_loads();
    test_timeout();
    test_ack_last();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
